// File: rtl/decoder_2x4_hold.sv
// Registered, handshaked binary-to-one-hot decoder that holds each decoded word for HOLD cycles.
// Optional even-parity checking on w is enabled by defining DECODER_2X4_PARITY_EN.
module decoder_2x4_hold #(
    parameter int IN_W  = 2,
    parameter int HOLD  = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [IN_W-1:0]      w,
`ifdef DECODER_2X4_PARITY_EN
    input  logic                 w_par,
    output logic                 par_err,
`endif
    output logic [2**IN_W-1:0]   y,
    output logic                 y_valid,
    output logic [CNT_W-1:0]     code_cnt
);
    localparam int OUT_W = 2**IN_W;
    localparam int HCW   = 8;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t         state;
    logic [HCW-1:0] hold_cnt;
    logic [OUT_W-1:0] dec;
    logic           accept;
    logic           par_ok;

    for (genvar i = 0; i < OUT_W; i++) begin : g_dec
        assign dec[i] = (w == IN_W'(i));
    end

`ifdef DECODER_2X4_PARITY_EN
    assign par_ok = ~^{w, w_par};
`else
    assign par_ok = 1'b1;
`endif

    // Ready again only in the final hold cycle so back-to-back codes leave no gap.
    assign w_ready = (state == S_IDLE) || (hold_cnt == '0);
    assign accept  = w_valid && w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            code_cnt <= '0;
`ifdef DECODER_2X4_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
`ifdef DECODER_2X4_PARITY_EN
            par_err <= 1'b0;
`endif
            if (accept && par_ok) begin
                state    <= S_HOLD;
                y        <= dec;
                y_valid  <= 1'b1;
                hold_cnt <= HCW'(HOLD - 1);
                code_cnt <= code_cnt + 1'b1;
            end else if (accept) begin
                // Bad parity: handshake completes, but the word is dropped.
                state    <= S_IDLE;
                y        <= '0;
                y_valid  <= 1'b0;
                hold_cnt <= '0;
`ifdef DECODER_2X4_PARITY_EN
                par_err  <= 1'b1;
`endif
            end else if (state == S_HOLD) begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end else begin
                    state   <= S_IDLE;
                    y       <= '0;
                    y_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_decoder_2x4_hold.sv
// Directed bench: HOLD=4 main instance, a HOLD=1 streaming instance and a CNT_W=3 wrap instance.
module tb_decoder_2x4_hold;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       w_valid = 1'b0, w_ready;
    logic [1:0] w = '0;
    logic [3:0] y;
    logic       y_valid;
    logic [7:0] code_cnt;

    logic       w_valid1 = 1'b0, w_ready1;
    logic [1:0] w1 = '0;
    logic [3:0] y1;
    logic       y_valid1;
    logic [7:0] code_cnt1;

    logic       w_valid3 = 1'b0, w_ready3;
    logic [1:0] w3 = '0;
    logic [3:0] y3;
    logic       y_valid3;
    logic [2:0] code_cnt3;

`ifdef DECODER_2X4_PARITY_EN
    logic w_par = 1'b0, par_err, par_err1, par_err3;
    logic w_par1, w_par3;
    assign w_par1 = ^w1;
    assign w_par3 = ^w3;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    decoder_2x4_hold #(.IN_W(2), .HOLD(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready), .w(w),
`ifdef DECODER_2X4_PARITY_EN
        .w_par(w_par), .par_err(par_err),
`endif
        .y(y), .y_valid(y_valid), .code_cnt(code_cnt));

    decoder_2x4_hold #(.IN_W(2), .HOLD(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .w_valid(w_valid1), .w_ready(w_ready1), .w(w1),
`ifdef DECODER_2X4_PARITY_EN
        .w_par(w_par1), .par_err(par_err1),
`endif
        .y(y1), .y_valid(y_valid1), .code_cnt(code_cnt1));

    decoder_2x4_hold #(.IN_W(2), .HOLD(1), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .w_valid(w_valid3), .w_ready(w_ready3), .w(w3),
`ifdef DECODER_2X4_PARITY_EN
        .w_par(w_par3), .par_err(par_err3),
`endif
        .y(y3), .y_valid(y_valid3), .code_cnt(code_cnt3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [1:0] v);
        w = v;
`ifdef DECODER_2X4_PARITY_EN
        w_par = ^v;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_y", y, 4'b0000);
        chk("rst_yv", y_valid, 1'b0);
        chk("rst_cnt", code_cnt, 8'd0);
        chk("rst_rdy", w_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Single code w=2, held exactly 4 cycles
        set_w(2'd2);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        set_w(2'd1);
        for (int j = 0; j < 4; j++) begin
            chk("t1_y", y, 4'b0100);
            chk("t1_yv", y_valid, 1'b1);
            chk("t1_rdy", w_ready, (j == 3) ? 1'b1 : 1'b0);
            tick();
        end
        chk("t1_y_off", y, 4'b0000);
        chk("t1_yv_off", y_valid, 1'b0);
        chk("t1_cnt", code_cnt, 8'd1);

        // Back-to-back stream, w_valid held high; junk w while not ready is ignored
        do_reset();
        set_w(2'd0);
        w_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int j = 0; j < 4; j++) begin
                chk("t2_y", y, 32'(1) << k);
                chk("t2_yv", y_valid, 1'b1);
                if (j < 3) begin
                    set_w(2'(k + 2));
                    tick();
                end else begin
                    set_w(2'(k + 1));
                end
            end
        end
        w_valid = 1'b0;
        tick();
        chk("t2_y_off", y, 4'b0000);
        chk("t2_cnt", code_cnt, 8'd4);

        // Asynchronous reset in hold cycle 2
        set_w(2'd3);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        tick();
        chk("t5_pre_y", y, 4'b1000);
        rst = 1'b1;
        #1;
        chk("t5_y", y, 4'b0000);
        chk("t5_yv", y_valid, 1'b0);
        chk("t5_cnt", code_cnt, 8'd0);
        tick();
        rst = 1'b0;
        set_w(2'd1);
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        chk("t5_after_y", y, 4'b0010);
        chk("t5_after_cnt", code_cnt, 8'd1);
        repeat (4) tick();
        chk("t5_after_off", y_valid, 1'b0);

        // HOLD=1 streaming
        w_valid1 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w1 = 2'(i % 4);
            chk("t3_rdy", w_ready1, 1'b1);
            tick();
            chk("t3_y", y1, 32'(1) << (i % 4));
            chk("t3_yv", y_valid1, 1'b1);
        end
        w_valid1 = 1'b0;
        tick();
        chk("t3_yv_off", y_valid1, 1'b0);
        chk("t3_cnt", code_cnt1, 8'd32);

        // CNT_W=3 wrap
        w_valid3 = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            w3 = 2'(n);
            tick();
            if (n == 7) chk("t4_cnt7", code_cnt3, 3'd7);
            if (n == 8) chk("t4_cnt8", code_cnt3, 3'd0);
        end
        w_valid3 = 1'b0;
        chk("t4_cnt9", code_cnt3, 3'd1);

`ifdef DECODER_2X4_PARITY_EN
        // Bad parity is consumed but not decoded
        tick();
        w = 2'd3;
        w_par = 1'b1;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        chk("par_err", par_err, 1'b1);
        chk("par_yv", y_valid, 1'b0);
        chk("par_y", y, 4'b0000);
        chk("par_cnt", code_cnt, 8'd1);
        chk("par_rdy", w_ready, 1'b1);
        tick();
        chk("par_err_clr", par_err, 1'b0);
        w_par = 1'b0;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("par_good_y", y, 4'b1000);
            tick();
        end
        chk("par_good_off", y_valid, 1'b0);
        chk("par_good_cnt", code_cnt, 8'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
